// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: instruction format, opcodes and
// the fetch-stage state type.
package cpu_pkg;

   localparam int unsigned INSTR_W = 8;
   localparam int unsigned OP_W    = 4;

   localparam logic [OP_W-1:0] MOVE = 4'b0000;
   localparam logic [OP_W-1:0] ADD  = 4'b0001;
   localparam logic [OP_W-1:0] SUB  = 4'b0010;
   localparam logic [OP_W-1:0] AND  = 4'b0011;
   localparam logic [OP_W-1:0] OR   = 4'b0100;
   localparam logic [OP_W-1:0] XOR  = 4'b0101;
   localparam logic [OP_W-1:0] SHL  = 4'b0110;
   localparam logic [OP_W-1:0] SHR  = 4'b0111;
   localparam logic [OP_W-1:0] J    = 4'b1000;
   localparam logic [OP_W-1:0] JAL  = 4'b1001;
   localparam logic [OP_W-1:0] LD   = 4'b1010;
   localparam logic [OP_W-1:0] ST   = 4'b1011;
   localparam logic [OP_W-1:0] BEQ  = 4'b1100;
   localparam logic [OP_W-1:0] BNE  = 4'b1101;
   localparam logic [OP_W-1:0] ADDI = 4'b1110;
   localparam logic [OP_W-1:0] LI   = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_t;

   function automatic logic [OP_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
      return instr[INSTR_W-1 -: OP_W];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack side, decoder valid/ready side
// and the execute-stage redirect inputs.
interface instr_fetch_unit_if
   import cpu_pkg::*;
#(
   parameter int PC_W = 8
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instruction;
   logic [PC_W-1:0]    instr_pc;
   logic               instr_valid;
   logic               instr_ready;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;

   modport master (
      output imem_req, imem_addr, instruction, instr_pc, instr_valid,
      input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
      output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory request, one-entry output
// register towards the decoder, redirect flushes wrong-path fetches.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_unit_if.master bus
);

   fetch_state_t    state, state_nxt;
   logic [PC_W-1:0] pc;
   logic            ack_seen;
   logic            transfer;
   logic            issue;
   logic            capture;
   logic            done;

   // Acks are only meaningful while a request is outstanding.
   assign ack_seen = (state != IDLE) && bus.imem_ack;
   assign transfer = bus.instr_valid && bus.instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (!bus.redirect && (!bus.instr_valid || bus.instr_ready)) state_nxt = WAIT;
         WAIT: begin
            if (ack_seen)          state_nxt = IDLE;
            else if (bus.redirect) state_nxt = DROP;
         end
         DROP: if (ack_seen) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      issue   = (state == IDLE) && !bus.redirect && (!bus.instr_valid || bus.instr_ready);
      capture = (state == WAIT) && ack_seen && !bus.redirect;
      done    = ack_seen;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc              <= RESET_PC;
         bus.imem_req    <= 1'b0;
         bus.imem_addr   <= '0;
         bus.instruction <= '0;
         bus.instr_pc    <= '0;
         bus.instr_valid <= 1'b0;
      end else begin
         if (bus.redirect)  pc <= bus.redirect_pc;
         else if (capture)  pc <= pc + 1'b1;

         if (issue) begin
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= pc;
         end else if (done) begin
            bus.imem_req  <= 1'b0;
         end

         if (capture) begin
            bus.instruction <= bus.imem_rdata;
            bus.instr_pc    <= bus.imem_addr;
         end

         // Redirect beats capture beats drain.
         if (bus.redirect)  bus.instr_valid <= 1'b0;
         else if (capture)  bus.instr_valid <= 1'b1;
         else if (transfer) bus.instr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, wrap and
// asynchronous-reset sequences, then randomized traffic against a model.
module tb_instr_fetch_unit;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.PC_W(8)) bus ();
   instr_fetch_unit_if #(.PC_W(8)) wbus ();

   instr_fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   instr_fetch_unit #(.PC_W(8), .RESET_PC(8'hFF)) dut_w (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (wbus.master)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       ready;
      logic       ack;
      logic [7:0] rdata;
      logic       redir;
      logic [7:0] rpc;
      logic       e_req;
      logic [7:0] e_addr;
      logic       e_valid;
      logic [7:0] e_instr;
      logic [7:0] e_pc;
   } vec_t;

   function automatic vec_t mk(input logic ready, input logic ack, input logic [7:0] rdata,
                               input logic redir, input logic [7:0] rpc,
                               input logic e_req, input logic [7:0] e_addr,
                               input logic e_valid, input logic [7:0] e_instr,
                               input logic [7:0] e_pc);
      vec_t v;
      v.ready = ready; v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_instr = e_instr; v.e_pc = e_pc;
      return v;
   endfunction

   vec_t       vt[$];
   logic [7:0] mem [256];

   // Reference-model state for the random phase.
   logic       o_req, o_valid, ack, ready, redir, ack_eff, transfer, cap, wanted;
   logic       x_valid;
   logic [7:0] o_addr, o_instr, o_pc, rpc, fetch_exp, x_addr, x_instr, x_pc;
   int         mode;

   initial begin
      // ready, ack, rdata, redir, rpc  |  req, addr, valid, instr, pc
      vt.push_back(mk(1, 0, 8'h00, 0, 8'h00,  1, 8'h00, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 1, 8'hEF, 0, 8'h00,  0, 8'h00, 1, 8'hEF, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 1, 8'hEF, 8'h00));
      vt.push_back(mk(0, 1, 8'h66, 0, 8'h00,  0, 8'h00, 1, 8'hEF, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 1, 8'hEF, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 1, 8'hEF, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 0, 8'h00,  0, 8'h00, 1, 8'hEF, 8'h00));
      vt.push_back(mk(1, 0, 8'h00, 0, 8'h00,  1, 8'h01, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 1, 8'h12, 0, 8'h00,  0, 8'h01, 1, 8'h12, 8'h01));
      vt.push_back(mk(1, 0, 8'h00, 0, 8'h00,  1, 8'h02, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 1, 8'h34, 0, 8'h00,  0, 8'h02, 1, 8'h34, 8'h02));
      vt.push_back(mk(1, 0, 8'h00, 0, 8'h00,  1, 8'h03, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 0, 8'h00, 1, 8'h40,  1, 8'h03, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 0, 8'h00, 0, 8'h00,  1, 8'h03, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 1, 8'h99, 0, 8'h00,  0, 8'h03, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 0, 8'h00, 0, 8'h00,  1, 8'h40, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 1, 8'hC5, 1, 8'h20,  0, 8'h40, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 0, 8'h00, 0, 8'h00,  1, 8'h20, 0, 8'h00, 8'h00));
      vt.push_back(mk(1, 1, 8'h56, 0, 8'h00,  0, 8'h20, 1, 8'h56, 8'h20));
      vt.push_back(mk(0, 0, 8'h00, 1, 8'h80,  0, 8'h20, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 0, 8'h00, 0, 8'h00,  1, 8'h80, 0, 8'h00, 8'h00));
      vt.push_back(mk(0, 1, 8'h77, 0, 8'h00,  0, 8'h80, 1, 8'h77, 8'h80));
      vt.push_back(mk(1, 0, 8'h00, 0, 8'h00,  1, 8'h81, 0, 8'h00, 8'h00));

      foreach (mem[i]) mem[i] = 8'($urandom);

      rst_n = 1'b0;
      bus.imem_ack = 0;  bus.imem_rdata = '0;  bus.instr_ready = 0;
      bus.redirect = 0;  bus.redirect_pc = '0;
      wbus.imem_ack = 0; wbus.imem_rdata = '0; wbus.instr_ready = 0;
      wbus.redirect = 0; wbus.redirect_pc = '0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      check("rst_req",   bus.imem_req,    0);
      check("rst_addr",  bus.imem_addr,   0);
      check("rst_instr", bus.instruction, 0);
      check("rst_pc",    bus.instr_pc,    0);
      check("rst_valid", bus.instr_valid, 0);
      check("rst_w_req", wbus.imem_req,   0);

      // Directed table; each row's outputs are checked one cycle later.
      rst_n = 1'b1;
      for (int unsigned k = 0; k < vt.size(); k++) begin
         bus.instr_ready = vt[k].ready;
         bus.imem_ack    = vt[k].ack;
         bus.imem_rdata  = vt[k].rdata;
         bus.redirect    = vt[k].redir;
         bus.redirect_pc = vt[k].rpc;
         @(negedge clk);
         check($sformatf("vec%0d_req", k),  bus.imem_req,    vt[k].e_req);
         check($sformatf("vec%0d_addr", k), bus.imem_addr,   vt[k].e_addr);
         check($sformatf("vec%0d_valid", k), bus.instr_valid, vt[k].e_valid);
         if (vt[k].e_valid) begin
            check($sformatf("vec%0d_instr", k), bus.instruction, vt[k].e_instr);
            check($sformatf("vec%0d_ipc", k),   bus.instr_pc,    vt[k].e_pc);
         end
      end
      bus.imem_ack = 0; bus.redirect = 0; bus.instr_ready = 1;

      // PC wrap from 0xFF.
      check("wrap_req0",  wbus.imem_req,  1);
      check("wrap_addr0", wbus.imem_addr, 8'hFF);
      wbus.imem_ack = 1; wbus.imem_rdata = 8'hA5; wbus.instr_ready = 1;
      @(negedge clk);
      wbus.imem_ack = 0;
      check("wrap_valid", wbus.instr_valid, 1);
      check("wrap_instr", wbus.instruction, 8'hA5);
      check("wrap_ipc",   wbus.instr_pc,    8'hFF);
      check("wrap_op",    opcode_of(wbus.instruction), 4'hA);
      @(negedge clk);
      check("wrap_req1",  wbus.imem_req,  1);
      check("wrap_addr1", wbus.imem_addr, 8'h00);

      // Asynchronous reset in the middle of a WAIT (main DUT waits at 0x81).
      check("mid_req_pre", bus.imem_req, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_req",   bus.imem_req,    0);
      check("mid_valid", bus.instr_valid, 0);
      check("mid_addr",  bus.imem_addr,   0);
      check("mid_w_req", wbus.imem_req,   0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_req",    bus.imem_req,   1);
      check("post_addr",   bus.imem_addr,  8'h00);
      check("post_w_req",  wbus.imem_req,  1);
      check("post_w_addr", wbus.imem_addr, 8'hFF);

      // Randomized traffic; main DUT has a wanted request outstanding at 0x00.
      wanted    = 1'b1;
      fetch_exp = 8'h00;
      mode      = 0;
      x_valid = 0; x_addr = 0; x_instr = 0; x_pc = 0;
      for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         o_req   = bus.imem_req;
         o_addr  = bus.imem_addr;
         o_valid = bus.instr_valid;
         o_instr = bus.instruction;
         o_pc    = bus.instr_pc;

         if (cyc > 0) begin
            check("rnd_valid", o_valid, x_valid);
            if (x_valid) begin
               check("rnd_instr", o_instr, x_instr);
               check("rnd_ipc",   o_pc,    x_pc);
            end
            if (mode == 1 || mode == 3) begin
               check("rnd_req_up", o_req,  1);
               check("rnd_addr",   o_addr, x_addr);
            end else begin
               check("rnd_req_dn", o_req, 0);
            end
         end

         ready = ($urandom_range(0, 3) != 0);
         redir = ($urandom_range(0, 9) == 0);
         rpc   = 8'($urandom);
         ack   = o_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         bus.instr_ready = ready;
         bus.redirect    = redir;
         bus.redirect_pc = rpc;
         bus.imem_ack    = ack;
         bus.imem_rdata  = o_req ? mem[o_addr] : 8'($urandom);

         // Transaction-level expectations for the next edge.
         ack_eff  = o_req && ack;
         transfer = o_valid && ready;
         if (o_req && redir) wanted = 1'b0;
         cap = ack_eff && wanted;
         if (o_req) mode = ack_eff ? 2 : 1;
         else       mode = (!redir && (!o_valid || ready)) ? 3 : 0;

         if (redir) x_valid = 1'b0;
         else if (cap) begin
            x_valid = 1'b1; x_instr = mem[o_addr]; x_pc = o_addr;
         end else if (transfer) x_valid = 1'b0;
         else begin
            x_valid = o_valid; x_instr = o_instr; x_pc = o_pc;
         end

         if (redir)    fetch_exp = rpc;
         else if (cap) fetch_exp = o_addr + 8'd1;

         if (mode == 3) begin
            x_addr = fetch_exp;
            wanted = 1'b1;
         end else begin
            x_addr = o_addr;
         end
         if (ack_eff) wanted = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
